// File: rtl/trig_gen.sv
// Debounced push-button trigger generator. It queues up to three events and issues each as a
// one-cycle pulse on a, handshaking with a downstream pulse stretcher through busy.
module trig_gen #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       busy,
  output logic       a,
  output logic [1:0] pend_cnt,
  output logic       overflow,
  output logic       no_ack
);

  localparam logic [3:0] DebLast  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] AckLimit = 4'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StFire, StWaitBusy, StWaitDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] sync_q;
  logic       deb_lvl_q, deb_lvl_d, deb_prev_q;
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic [3:0] tmo_q, tmo_d;
  logic [1:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       noack_q, noack_d;
  logic       a_q;
  logic       key_s, rise, fire;

  assign key_s = sync_q[1];
  // Only 0->1 transitions of the debounced level are events.
  assign rise  = deb_lvl_q & ~deb_prev_q;
  assign fire  = (state_q == StFire);

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (key_s != deb_lvl_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_lvl_d = key_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (rise && !fire) begin
      if (pend_q == 2'd3) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 2'd1;
      end
    end else if (fire && !rise) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    noack_d = noack_q;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (pend_q != 2'd0 && !busy) state_d = StFire;
      end
      StFire: begin
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (busy) begin
          state_d = StWaitDone;
        end else begin
          tmo_d = tmo_q + 4'd1;
          if (tmo_d == AckLimit) begin
            state_d = StIdle;
            noack_d = 1'b1;
          end
        end
      end
      StWaitDone: begin
        if (!busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      tmo_q      <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      noack_q    <= 1'b0;
      a_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], key_in};
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
      deb_cnt_q  <= deb_cnt_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      noack_q    <= noack_d;
      a_q        <= (state_d == StFire);
    end
  end

  assign a        = a_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;
  assign no_ack   = noack_q;

endmodule

// File: doc/trig_gen.md
TRIG_GEN -- requirements
Module: trig_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 4: cycles key_s must differ from the debounced level before the level flips; legal range 2..15.
REQ-002 Parameter ACK_TIMEOUT, default 7: maximum cycles in WAIT_BUSY before abort; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 key_in  input  1  raw asynchronous trigger source, such as a push-button.
REQ-006 busy  input  1  b output of the downstream pulse stretcher; high while its stretched pulse is active.
REQ-007 a  output  1  single-cycle trigger pulse to the downstream stretcher's a input; registered.
REQ-008 pend_cnt  output  2  number of accepted-but-unissued trigger events; registered.
REQ-009 overflow  output  1  sticky flag: an event was dropped because pend_cnt was saturated; registered.
REQ-010 no_ack  output  1  sticky flag: busy failed to rise within ACK_TIMEOUT cycles of a; registered.

Function
REQ-011 key_in shall pass through a 2-flop synchronizer; key_s is the second flop's output.
REQ-012 Debounce shall use a 4-bit counter deb_cnt and a level register deb_lvl:
- key_s == deb_lvl: deb_cnt <= 0.
- Otherwise, deb_cnt != DEB_CYCLES-1: deb_cnt increments.
- Otherwise, deb_cnt == DEB_CYCLES-1: deb_lvl <= key_s and deb_cnt <= 0.
REQ-013 Any single key_s sample equal to deb_lvl shall restart the debounce count, so glitches shorter than DEB_CYCLES cycles are never seen.
REQ-014 rise shall be an internal one-cycle strobe, high in the cycle after deb_lvl goes 0->1; 1->0 transitions produce no event.
REQ-015 pend_cnt shall change on each edge as follows:
- rise and not fire: +1.
- fire and not rise: -1.
- rise and fire together: unchanged.
- Saturates at 3.
REQ-016 A rise with pend_cnt==3 and no simultaneous fire shall leave pend_cnt at 3 and set overflow; overflow clears only on reset.
REQ-017 The FSM shall have four states, IDLE, FIRE, WAIT_BUSY and WAIT_DONE, encoded in 2 bits.
REQ-018 IDLE -> FIRE when pend_cnt != 0 and busy == 0; otherwise stay in IDLE.
REQ-019 FIRE lasts exactly one cycle and always -> WAIT_BUSY; fire == (state == FIRE); a shall be high exactly while in FIRE.
REQ-020 WAIT_BUSY -> WAIT_DONE when busy == 1. A 4-bit timer tmo counts WAIT_BUSY cycles; when tmo reaches ACK_TIMEOUT, the FSM -> IDLE and sets no_ack, which is sticky until reset.
REQ-021 WAIT_DONE -> IDLE when busy == 0.
REQ-022 a shall never be high in two consecutive cycles and never high while busy == 1 was sampled in the same cycle's state decision.
REQ-023 Latency from the first clk edge sampling key_in = 1, with the line held stable, FSM in IDLE and busy low:
- deb_lvl rises at edge 2+DEB_CYCLES.
- pend_cnt becomes 1 at edge 3+DEB_CYCLES.
- a is high for the cycle following edge 4+DEB_CYCLES, which is edge 8 with defaults.
REQ-024 Events arriving while the FSM is in FIRE, WAIT_BUSY or WAIT_DONE shall be queued in pend_cnt and issued in order, one per IDLE pass.

Reset
REQ-025 With rst == 0 at a rising edge, the block shall load:
- Synchronizer flops, deb_lvl, deb_cnt and tmo: 0.
- pend_cnt: 0; a, overflow, no_ack: 0.
- FSM: IDLE.
REQ-026 Reset mid-operation, in any state, shall discard pending events and shall not produce a truncated or extra pulse on a.
REQ-027 The first a after rst is released requires a fresh debounced rising edge; a key_in already high at release counts as a rise once debounced.
REQ-028 Reset shall have no asynchronous path; between edges, rst changes shall have no effect.

Verification
REQ-029 Clean press: key_in 0->1, held for 20 cycles, busy modelled as 4-cycle stretcher starting 1 cycle after a -> exactly one 1-cycle a at edge 8, pend_cnt 0->1->0, no flags.
REQ-030 Glitch rejection: key_in high for 3 cycles, then low, DEB_CYCLES = 4 -> deb_lvl stays 0, no a, pend_cnt stays 0.
REQ-031 Burst: 5 debounced presses issued while busy is held high by the bench -> pend_cnt saturates at 3, overflow = 1; after busy falls, exactly 3 a pulses, each separated by a full busy cycle.
REQ-032 Simultaneous rise and fire with pend_cnt = 1 -> pend_cnt stays 1, one a issued, next a issued after busy completes.
REQ-033 No acknowledge: busy tied 0 -> after a, 7 cycles in WAIT_BUSY, then IDLE, no_ack = 1, and the next pending event is issued.
REQ-034 Reset asserted during WAIT_DONE with pend_cnt = 2 -> next edge: state IDLE, pend_cnt 0, a 0, flags 0; no a until a new debounced press.
